// File: rtl/egress_cpld_gen_pkg.sv
// Shared TLP constants, request/header types and FSM encoding for egress_cpld_gen.
// Header DW layout follows the PCIe 3DW completion-with-data format.
package egress_cpld_gen_pkg;

    localparam logic [2:0]  FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0]  TYPE_CPL       = 5'b01010;
    localparam logic [2:0]  CPL_STATUS_SC  = 3'b000;
    localparam logic [2:0]  CPL_STATUS_UR  = 3'b001;
    localparam logic [2:0]  CPL_STATUS_CA  = 3'b100;
    localparam logic [9:0]  LENGTH_1DW     = 10'd1;
    localparam logic [11:0] BYTE_COUNT_1DW = 12'd4;

    typedef struct packed {
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [15:0] id;
        logic [7:0]  tag;
        logic [6:0]  addr_lo;
    } req_entry_t;

    typedef struct packed {
        logic [31:0] dw2;
        logic [31:0] dw1;
        logic [31:0] dw0;
    } cpld_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } cpl_state_t;

    function automatic cpld_hdr_t build_cpld_hdr(input req_entry_t req, input logic [15:0] cmpl_id);
        cpld_hdr_t hdr;
        hdr.dw0 = {FMT_3DW_DATA, TYPE_CPL, 1'b0, req.tc, 4'b0000, 1'b0, 1'b0,
                   req.attr, 2'b00, LENGTH_1DW};
        hdr.dw1 = {cmpl_id, CPL_STATUS_SC, 1'b0, BYTE_COUNT_1DW};
        hdr.dw2 = {req.id, req.tag, 1'b0, req.addr_lo};
        return hdr;
    endfunction

endpackage

// File: rtl/egress_cpld_gen_cpl_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of 2.
// Head entry is presented combinationally on o_data while not empty.
module cpl_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/egress_cpld_gen.sv
// Pairs accepted read requests with returned register data and emits 2-beat 1-DW CplD TLPs.
// Define EGRESS_CPLD_BYTE_SWAP_EN to byte-reverse the payload DW.
module egress_cpld_gen
    import egress_cpld_gen_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       completer_id,
    input  logic              req_valid,
    output logic              req_rdy,
    input  logic [15:0]       req_id,
    input  logic [7:0]        req_tag,
    input  logic [2:0]        req_tc,
    input  logic [1:0]        req_attr,
    input  logic [6:0]        req_addr_lo,
    input  logic [31:0]       rd_data,
    input  logic              rd_data_valid,
    output logic [DATA_W-1:0] cpl_data,
    output logic [KEEP_W-1:0] cpl_keep,
    output logic              cpl_valid,
    output logic              cpl_last,
    input  logic              cpl_rdy,
    output logic              err_orphan,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(REQ_DEPTH) + 1;

    cpl_state_t  r_state;
    cpl_state_t  w_state_next;
    logic [CW-1:0] r_outstanding;
    logic [15:0] r_cmpl_id;
    logic        r_err_orphan;

    req_entry_t  w_req_in;
    req_entry_t  w_req_head;
    logic [31:0] w_dat_head;
    logic [31:0] w_payload;
    cpld_hdr_t   w_hdr;
    logic [CW-1:0] w_req_count;
    logic [CW-1:0] w_dat_count;
    logic        w_req_empty;
    logic        w_req_full;
    logic        w_dat_empty;
    logic        w_dat_full;
    logic        w_req_accept;
    logic        w_data_accept;
    logic        w_cpl_done;
    logic        w_req_more;
    logic        w_dat_more;

    assign req_rdy       = rst_n && (r_outstanding != CW'(REQ_DEPTH)) && !w_req_full;
    assign w_req_accept  = req_valid && req_rdy;
    assign w_cpl_done    = (r_state == ST_DATA) && cpl_rdy;
    // Data is only legitimate while some accepted request is still waiting for its value.
    assign w_data_accept = rd_data_valid && (r_outstanding > w_dat_count) && !w_dat_full;
    assign w_req_in      = '{tc: req_tc, attr: req_attr, id: req_id, tag: req_tag, addr_lo: req_addr_lo};
    assign err_orphan    = r_err_orphan;
    assign dbg_state     = r_state;

`ifdef EGRESS_CPLD_BYTE_SWAP_EN
    assign w_payload = {w_dat_head[7:0], w_dat_head[15:8], w_dat_head[23:16], w_dat_head[31:24]};
`else
    assign w_payload = w_dat_head;
`endif

    assign w_hdr = build_cpld_hdr(w_req_head, r_cmpl_id);

    cpl_sync_fifo #(.WIDTH($bits(req_entry_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_req_accept),
        .i_data  (w_req_in),
        .i_pop   (w_cpl_done),
        .o_data  (w_req_head),
        .o_empty (w_req_empty),
        .o_full  (w_req_full),
        .o_count (w_req_count)
    );

    cpl_sync_fifo #(.WIDTH(32), .DEPTH(REQ_DEPTH)) u_dat_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_data_accept),
        .i_data  (rd_data),
        .i_pop   (w_cpl_done),
        .o_data  (w_dat_head),
        .o_empty (w_dat_empty),
        .o_full  (w_dat_full),
        .o_count (w_dat_count)
    );

    // Entries remaining after the DATA-beat pop, counting a same-cycle push.
    assign w_req_more = (w_req_count > CW'(1)) || w_req_accept;
    assign w_dat_more = (w_dat_count > CW'(1)) || w_data_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_outstanding <= '0;
            r_cmpl_id     <= '0;
            r_err_orphan  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case ({w_req_accept, w_cpl_done})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_state_next == ST_HDR && r_state != ST_HDR) begin
                r_cmpl_id <= completer_id;
            end
            if (rd_data_valid && !w_data_accept) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        cpl_valid    = 1'b0;
        cpl_last     = 1'b0;
        cpl_keep     = '0;
        cpl_data     = '0;
        case (r_state)
            ST_IDLE: begin
                if (!w_req_empty && !w_dat_empty) begin
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                cpl_valid = 1'b1;
                cpl_keep  = {KEEP_W{1'b1}};
                cpl_data  = {w_hdr.dw1, w_hdr.dw0};
                if (cpl_rdy) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                cpl_valid = 1'b1;
                cpl_last  = 1'b1;
                cpl_keep  = {KEEP_W{1'b1}};
                cpl_data  = {w_payload, w_hdr.dw2};
                if (cpl_rdy) begin
                    w_state_next = (w_req_more && w_dat_more) ? ST_HDR : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
